// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a word-addressed data memory.
//   Byte/half/word loads and stores become word accesses. Sub-word stores use
//   read-modify-write, and loads are lane-extracted and then sign- or zero-extended.
//   Misaligned, out-of-range or reserved-size requests skip memory and report rsp_err.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready handshake; req_we, req_size, req_signed, req_addr, req_wdata, req_pc
//   done/rsp_err/rsp_rdata response (done is a one-cycle pulse)
//   dm_MemWrite, dm_storeSig, dm_A, dm_WData, dm_PC, dm_addr to memory; dm_RData from memory
module mem_access_unit #(
    parameter int ADDR_W      = 10,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              done,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              dm_MemWrite,
    output logic [3:0]        dm_storeSig,
    output logic [ADDR_W-1:0] dm_A,
    output logic [31:0]       dm_WData,
    output logic [31:0]       dm_PC,
    output logic [31:0]       dm_addr,
    input  logic [31:0]       dm_RData
);
    typedef enum logic [2:0] {IDLE, ERR, WR, RD, LD} state_t;
    state_t r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_pc, r_merge, r_rdata;
    logic [1:0]  r_size;
    logic        r_signed, r_done, r_err;
    logic        w_err;
    logic [31:0] w_addr_al, w_wsh, w_rsh, w_mask, w_ld;
    logic [3:0]  w_lanes;

    assign w_err = (req_size == 2'b11)
                || (CHECK_ALIGN && ((req_size == 2'b01 && req_addr[0])
                                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00)))
                || (req_addr[31:ADDR_W+2] != '0);
    // With alignment checking off, the low address bits are dropped so the access is aligned.
    assign w_addr_al = CHECK_ALIGN ? req_addr
                     : {req_addr[31:2], req_size == 2'b10 ? 2'b00
                                      : req_size == 2'b01 ? {req_addr[1], 1'b0}
                                      : req_addr[1:0]};

    assign w_lanes = r_size == 2'b10 ? 4'b1111
                   : r_size == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011)
                   : 4'b0001 << r_addr[1:0];
    assign w_mask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}}, {8{w_lanes[1]}}, {8{w_lanes[0]}}};
    assign w_wsh   = r_wdata << {r_addr[1:0], 3'b000};
    assign w_rsh   = dm_RData >> {r_addr[1:0], 3'b000};
    assign w_ld    = r_size == 2'b00 ? {{24{r_signed & w_rsh[7]}}, w_rsh[7:0]}
                   : r_size == 2'b01 ? {{16{r_signed & w_rsh[15]}}, w_rsh[15:0]}
                   : w_rsh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = IDLE;
        if (r_state == IDLE)
            w_next = !req_valid ? IDLE
                   : w_err ? ERR
                   : !req_we ? LD
                   : req_size == 2'b10 ? WR : RD;
        else if (r_state == RD)
            w_next = WR;
    end

    always_comb begin
        req_ready   = r_state == IDLE;
        dm_MemWrite = r_state == WR;
        dm_storeSig = r_state == WR ? w_lanes : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= r_state == WR || r_state == LD || r_state == ERR;
            r_err  <= r_state == ERR;
            if (r_state == LD) r_rdata <= w_ld;
            else if (r_state == WR || r_state == ERR) r_rdata <= '0;
            if (r_state == RD) r_merge <= dm_RData;
            if (r_state == IDLE && req_valid) begin
                r_addr   <= w_addr_al;
                r_wdata  <= req_wdata;
                r_pc     <= req_pc;
                r_size   <= req_size;
                r_signed <= req_signed;
            end
        end
    end

    assign done      = r_done;
    assign rsp_err   = r_err;
    assign rsp_rdata = r_rdata;
    assign dm_A      = r_addr[ADDR_W+1:2];
    assign dm_addr   = {r_addr[31:2], 2'b00};
    assign dm_PC     = r_pc;
    // Word stores have a full lane mask, so the stale merge register never leaks into them.
    assign dm_WData  = (r_merge & ~w_mask) | (w_wsh & w_mask);
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a behavioural data memory.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        done, rsp_err, dm_MemWrite;
    logic [31:0] rsp_rdata, dm_WData, dm_PC, dm_addr, dm_RData;
    logic [3:0]  dm_storeSig;
    logic [9:0]  dm_A;
    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    logic [32:0]  rq [$];
    logic [109:0] wq [$];
    int checks = 0, failures = 0;
    int waited;

    mem_access_unit #(.ADDR_W(10), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .done(done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .dm_MemWrite(dm_MemWrite), .dm_storeSig(dm_storeSig), .dm_A(dm_A),
        .dm_WData(dm_WData), .dm_PC(dm_PC), .dm_addr(dm_addr), .dm_RData(dm_RData)
    );

    always #5 clk = ~clk;

    assign dm_RData = mem[dm_A];
    always @(posedge clk) begin
        if (dm_MemWrite) mem[dm_A] <= dm_WData;
        else if (pre_en) mem[pre_a] <= pre_d;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (rq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else chk("response", {rsp_err, rsp_rdata}, rq.pop_front());
        end
        if (dm_MemWrite) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h expected=none", dm_WData);
            end else chk("write", {dm_A, dm_addr, dm_WData, dm_storeSig, dm_PC}, wq.pop_front());
        end
    end

    task automatic rsp_exp(input logic err, input logic [31:0] d);
        rq.push_back({err, d});
    endtask

    task automatic wr_exp(input logic [9:0] idx, input logic [31:0] d, input logic [3:0] sig,
                          input logic [31:0] pc);
        wq.push_back({idx, {20'h0, idx, 2'b00}, d, sig, pc});
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 expected=1");
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        int n;
        wait_ready(n);
        pre_a = a;
        pre_d = d;
        pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] pc, output int n);
        wait_ready(n);
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        req_pc = pc;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", {done, rsp_err}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_mw", {dm_MemWrite, dm_storeSig}, 0);
        chk("rst_dm", {dm_A, dm_WData, dm_PC, dm_addr}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_write", {dm_MemWrite, dm_storeSig, done}, 0);

        rsp_exp(0, 0);
        wr_exp(10'd4, 32'hDEADBEEF, 4'b1111, 32'h100);
        req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h100, waited);
        @(negedge clk);
        chk("sw_write_cycle", {dm_MemWrite, done, req_ready}, 3'b100);
        @(negedge clk);
        chk("sw_done_cycle", {dm_MemWrite, done, req_ready}, 3'b011);

        preload(10'd4, 32'h11223344);
        rsp_exp(0, 0);
        wr_exp(10'd4, 32'h11AB3344, 4'b0100, 32'h104);
        req(1, 2'b00, 0, 32'h12, 32'h000000AB, 32'h104, waited);
        preload(10'd8, 32'hAAAAAAAA);
        rsp_exp(0, 0);
        wr_exp(10'd8, 32'hBEEFAAAA, 4'b1100, 32'h108);
        req(1, 2'b01, 0, 32'h22, 32'h1234BEEF, 32'h108, waited);

        preload(10'd5, 32'h80017F00);
        rsp_exp(0, 32'hFFFF8001); req(0, 2'b01, 1, 32'h16, 0, 32'h110, waited);
        rsp_exp(0, 32'h0000007F); req(0, 2'b00, 0, 32'h15, 0, 32'h114, waited);
        rsp_exp(0, 32'hFFFFFF80); req(0, 2'b00, 1, 32'h17, 0, 32'h118, waited);
        rsp_exp(0, 32'h00008001); req(0, 2'b01, 0, 32'h16, 0, 32'h11C, waited);
        rsp_exp(0, 32'h80017F00); req(0, 2'b10, 1, 32'h14, 0, 32'h120, waited);
        rsp_exp(0, 32'h00000000); req(0, 2'b00, 1, 32'h14, 0, 32'h124, waited);
        preload(10'd1023, 32'hCAFEF00D);
        rsp_exp(0, 32'hCAFEF00D); req(0, 2'b10, 0, 32'hFFC, 0, 32'h128, waited);

        rsp_exp(1, 0); req(0, 2'b10, 0, 32'h13, 0, 32'h130, waited);
        rsp_exp(1, 0); req(1, 2'b01, 0, 32'h1000, 32'h5555, 32'h134, waited);
        rsp_exp(1, 0); req(1, 2'b11, 0, 32'h10, 32'h1, 32'h138, waited);
        rsp_exp(1, 0); req(1, 2'b01, 0, 32'h11, 32'h2, 32'h13C, waited);
        rsp_exp(1, 0); req(0, 2'b10, 0, 32'h12, 0, 32'h140, waited);
        rsp_exp(1, 0); req(1, 2'b10, 0, 32'hFFFFFFFC, 32'h3, 32'h144, waited);
        rsp_exp(0, 32'h80017F00); req(0, 2'b10, 0, 32'h14, 0, 32'h148, waited);

        preload(10'd6, 32'h01020304);
        req(1, 2'b01, 0, 32'h18, 32'h0000FFFF, 32'h200, waited);
        reset = 1'b0;
        #2;
        chk("rst_mid_state", {req_ready, dm_MemWrite, done}, 3'b100);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_mem", mem[6], 32'h01020304);
        chk("rst_mid_idle", {req_ready, dm_MemWrite}, 2'b10);

        rsp_exp(0, 0);
        wr_exp(10'd16, 32'h0BADF00D, 4'b1111, 32'h300);
        req(1, 2'b10, 0, 32'h40, 32'h0BADF00D, 32'h300, waited);
        rsp_exp(0, 32'h0BADF00D);
        req(0, 2'b10, 0, 32'h40, 0, 32'h304, waited);
        chk("b2b_accept_in_done", waited, 1);

        for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
        chk("drain", {rq.size(), wq.size()}, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
